// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Active-low push-button conditioner: sync, debounce, press/release/
//            long-press events and a wrapping press counter.
// Revision : 1.0
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CNT = 1_000_000,
    parameter int LONG_CNT     = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_PRESS_DB   = 2'd1,
        S_HELD       = 2'd2,
        S_RELEASE_DB = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_db_max   = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] c_long_max = CNT_W'(LONG_CNT - 1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_long_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic             w_long_done_nxt;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_long_nxt;
    logic [7:0]       w_count_nxt;

    // Synchronisers reset to 1 so a key held through reset is seen as a fresh press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= S_IDLE;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            press_count <= 8'd0;
        end else begin
            r_sync1     <= key_in;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_db_cnt    <= w_db_cnt_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_long_done <= w_long_done_nxt;
            key_level   <= w_level_nxt;
            key_press   <= w_press_nxt;
            key_release <= w_release_nxt;
            key_long    <= w_long_nxt;
            press_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_db_cnt_nxt    = r_db_cnt;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_long_done_nxt = r_long_done;
        w_level_nxt     = key_level;
        w_press_nxt     = 1'b0;
        w_release_nxt   = 1'b0;
        w_long_nxt      = 1'b0;
        w_count_nxt     = press_count;

        // Hold timer keeps running through release bounce so long-press timing is unaffected
        if (r_state == S_HELD || r_state == S_RELEASE_DB) begin
            if (r_hold_cnt != c_long_max) begin
                w_hold_cnt_nxt = r_hold_cnt + 1'b1;
            end else if (!r_long_done) begin
                w_long_nxt      = 1'b1;
                w_long_done_nxt = 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (!r_sync2) begin
                    w_state_nxt  = S_PRESS_DB;
                    w_db_cnt_nxt = '0;
                end
            end
            S_PRESS_DB: begin
                if (r_sync2) begin
                    w_state_nxt = S_IDLE;
                end else if (r_db_cnt == c_db_max) begin
                    w_state_nxt     = S_HELD;
                    w_press_nxt     = 1'b1;
                    w_level_nxt     = 1'b1;
                    w_count_nxt     = press_count + 8'd1;
                    w_hold_cnt_nxt  = '0;
                    w_long_done_nxt = 1'b0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            S_HELD: begin
                if (r_sync2) begin
                    w_state_nxt  = S_RELEASE_DB;
                    w_db_cnt_nxt = '0;
                end
            end
            S_RELEASE_DB: begin
                if (!r_sync2) begin
                    w_state_nxt = S_HELD;
                end else if (r_db_cnt == c_db_max) begin
                    w_state_nxt     = S_IDLE;
                    w_release_nxt   = 1'b1;
                    w_level_nxt     = 1'b0;
                    w_hold_cnt_nxt  = '0;
                    w_long_done_nxt = 1'b0;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
